// File: rtl/neuron_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron body.
package neuron_pkg;

  localparam int unsigned POT_W_DEF = 16;
  localparam int unsigned REF_W_DEF = 4;

  // Saturation bounds of the default-width membrane potential
  localparam logic signed [POT_W_DEF-1:0] POT_MAX = {1'b0, {(POT_W_DEF-1){1'b1}}};
  localparam logic signed [POT_W_DEF-1:0] POT_MIN = {1'b1, {(POT_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    LEAK      = 2'd2,
    FIRE      = 2'd3
  } state_e;

  // Sign-extend an 8-bit contribution to the widened (POT_W_DEF+1) sum width
  function automatic logic signed [POT_W_DEF:0] sext8(input logic signed [7:0] x);
    return {{(POT_W_DEF-7){x[7]}}, x};
  endfunction

endpackage

// File: rtl/neuron_integrator_if.sv
// Synapse contribution stream: valid/ready handshake with a last-beat marker.
interface neuron_integrator_if;

  logic       syn_valid;
  logic [7:0] syn_data;
  logic       syn_last;
  logic       syn_ready;

  modport master (output syn_valid, output syn_data, output syn_last, input syn_ready);
  modport slave  (input syn_valid, input syn_data, input syn_last, output syn_ready);

endinterface

// File: rtl/sat_add.sv
// Signed W-bit + signed 8-bit adder clamped to the W-bit two's-complement range.
module sat_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [7:0]   b_i,
  output logic [W-1:0] sum_o
);

  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] wide;

  // One extra bit cannot overflow; disagreeing top bits flag out-of-range results
  always_comb begin
    wide = {a_i[W-1], a_i} + {{(W-7){b_i[7]}}, b_i};
    if (wide[W] != wide[W-1]) begin
      sum_o = wide[W] ? MIN_V : MAX_V;
    end else begin
      sum_o = wide[W-1:0];
    end
  end

endmodule

// File: rtl/neuron_integrator.sv
// Leaky integrate-and-fire neuron: per-tick accumulate, leak, threshold, refractory.
module neuron_integrator
  import neuron_pkg::*;
#(
  parameter int unsigned POT_W = POT_W_DEF,
  parameter int unsigned REF_W = REF_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  neuron_integrator_if.slave syn,
  input  logic [7:0]         leak,
  input  logic [POT_W-1:0]   threshold,
  input  logic [POT_W-1:0]   reset_pot,
  input  logic [REF_W-1:0]   refrac_ticks,
  output logic               spike,
  output logic [POT_W-1:0]   potential,
  output logic               refractory,
  output logic               busy,
  output logic               tick_overrun
);

  state_e           state_q;
  logic [POT_W-1:0] pot_q;
  logic [POT_W-1:0] pot_d;
  logic [REF_W-1:0] ref_q;
  logic             spike_q;
  logic             ovr_q;
  logic [7:0]       addend;
  logic             in_refr;
  logic             crossed;

  // Single shared saturating adder: leak in LEAK, synapse beat otherwise
  assign addend = (state_q == LEAK) ? leak : syn.syn_data;

  sat_add #(.W(POT_W)) u_sat_add (
    .a_i   (pot_q),
    .b_i   (addend),
    .sum_o (pot_d)
  );

  assign in_refr = (ref_q != '0);
  assign crossed = ($signed(pot_q) >= $signed(threshold));

  // Control FSM plus potential, refractory counter, spike and overrun registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pot_q   <= '0;
      ref_q   <= '0;
      spike_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      if (tick && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= INTEGRATE;
          end
        end
        INTEGRATE: begin
          if (syn.syn_valid) begin
            // Refractory beats are still consumed, just not accumulated
            if (!in_refr) begin
              pot_q <= pot_d;
            end
            if (syn.syn_last) begin
              state_q <= LEAK;
            end
          end
        end
        LEAK: begin
          if (!in_refr) begin
            pot_q <= pot_d;
          end
          state_q <= FIRE;
        end
        FIRE: begin
          if (!in_refr && crossed) begin
            spike_q <= 1'b1;
            pot_q   <= reset_pot;
            ref_q   <= refrac_ticks;
          end else if (in_refr) begin
            ref_q <= ref_q - REF_W'(1);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign syn.syn_ready = (state_q == INTEGRATE);
  assign busy          = (state_q != IDLE);
  assign spike         = spike_q;
  assign potential     = pot_q;
  assign refractory    = in_refr;
  assign tick_overrun  = ovr_q;

endmodule

// File: doc/neuron_integrator.md
# neuron_integrator

Leaky integrate-and-fire neuron body sitting directly downstream of the synapse stage. Once per tick it accumulates a stream of signed 8-bit synapse contributions into a saturating membrane potential, applies a signed leak and compares against a threshold. On crossing it emits a one-cycle spike, loads the reset potential and enters a tick-counted refractory period. Output spikes feed the router/axon-event stage.

## Interface
Parameters:
- POT_W, 16, membrane potential width (signed, two's complement)
- REF_W, 4, refractory counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- tick  in  1  global time-step strobe, single-cycle pulse
- syn_valid  in  1  contribution beat valid
- syn_data  in  8  signed contribution from synapse stage (8'hFF = -1)
- syn_last  in  1  marks final beat of this tick's stream
- syn_ready  out  1  beat accepted when syn_valid && syn_ready
- leak  in  8  signed leak added once per tick
- threshold  in  POT_W  firing threshold, signed, compared with >=
- reset_pot  in  POT_W  potential loaded after a spike
- refrac_ticks  in  REF_W  ticks of refractory after a spike (0 = none)
- spike  out  1  one-cycle fire pulse
- potential  out  POT_W  current membrane potential
- refractory  out  1  refractory counter nonzero
- busy  out  1  state != IDLE
- tick_overrun  out  1  sticky: tick arrived while busy

## Operation
- States: IDLE, INTEGRATE, LEAK, FIRE.
- IDLE: on tick -> INTEGRATE. syn_ready=0.
- INTEGRATE: syn_ready=1. Each accepted beat: potential <= sat(potential + sext(syn_data)) unless refractory, in which case beat is consumed and discarded. Accepted beat with syn_last=1 -> LEAK. Zero-beat tick: upstream sends one beat syn_data=0, syn_last=1.
- LEAK: potential <= sat(potential + sext(leak)) unless refractory (skipped). -> FIRE.
- FIRE: if not refractory and potential >= threshold: spike <= 1, potential <= reset_pot, ref_cnt <= refrac_ticks. Else if refractory: ref_cnt <= ref_cnt - 1. -> IDLE.
- Saturation: sum formed at POT_W+1 bits, clamped to [-2^(POT_W-1), 2^(POT_W-1)-1]; no wrap-around ever.
- tick while state != IDLE: ignored, tick_overrun <= 1 (cleared only by reset).
- syn_valid outside INTEGRATE: ignored, no effect.
- Config inputs (leak, threshold, reset_pot, refrac_ticks) sampled live; must be stable from tick to FIRE.
- Reset mid-operation: all state returns to reset values immediately; partial tick discarded.

## Timing
- Reset values: state IDLE, potential 0, ref_cnt 0, spike 0, syn_ready 0, refractory 0, busy 0, tick_overrun 0.
- tick at cycle T -> syn_ready=1 from T+1.
- Last beat accepted at L -> LEAK at L+1, FIRE at L+2, spike=1 and potential=reset_pot at L+3, busy=0 at L+3.
- Tick at L+3 is accepted (no dead cycle).
- Minimum tick period: beats + 3 cycles.
- syn_ready and busy are registered-state decodes; spike is a registered one-cycle pulse.
- refractory reflects ref_cnt after FIRE update; refrac_ticks=N blocks exactly the next N ticks.

## Structure
- Package neuron_pkg: state enum (IDLE, INTEGRATE, LEAK, FIRE), POT_MAX/POT_MIN constants derived from POT_W, sign-extend function.
- Sub-module sat_add: POT_W signed + 8-bit signed -> clamped POT_W result; instantiated once, operand muxed between syn_data and leak.

## Test plan
- Integrate/fire: threshold=10, leak=0, beats 4,4,3(last) -> potential 11 at L+2, spike at L+3, potential=reset_pot=0.
- Leak and negative contributions: leak=-2 (8'hFE), beats 8'hFF,8'h05(last) from 0 -> potential 2, no spike.
- Saturation: potential near 32760, beat +100 -> 32767; from -32760, beat -100 -> -32768; never wraps.
- Refractory: refrac_ticks=2, fire on tick 1; ticks 2-3 with beat +50 each -> potential unchanged, no spike; tick 4 integrates normally.
- Overrun: tick during INTEGRATE -> tick_overrun=1, state unaffected, stays 1 until rst.
- Reset mid-INTEGRATE: assert rst after two beats -> potential 0, IDLE, syn_ready 0 immediately; next tick starts clean.
